exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and HI/LO result width; legal values are 8 to 64, even.
REQ-002 Parameter CNT_W, default 6, sets the iteration counter width; CNT_W SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 md_valid  input  1  request strobe from the EXE stage (EXE_valid & mul_or_div).
REQ-006 md_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 md_src1  input  WIDTH  multiplicand or dividend.
REQ-008 md_src2  input  WIDTH  multiplier or divisor.
REQ-009 md_cancel  input  1  flush from exception or eret; aborts the operation in flight.
REQ-010 md_busy  output  1  high in BUSY and DONE states.
REQ-011 md_over  output  1  one-cycle completion pulse; the EXE stage SHALL form EXE_over = EXE_valid & (~mul_or_div | md_over).
REQ-012 md_hi  output  WIDTH  product upper half, or remainder.
REQ-013 md_lo  output  WIDTH  product lower half, or quotient.
REQ-014 md_div_zero  output  1  last completed divide had divisor 0.

Function
REQ-015 The FSM SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE->BUSY on md_valid & ~md_cancel.
- BUSY->DONE when the counter reaches WIDTH-1.
- DONE->IDLE unconditionally.
REQ-016 Operands and md_op SHALL be captured only at the accepting edge; later changes to the inputs SHALL NOT affect the result.
REQ-017 md_valid SHALL be ignored in BUSY and DONE; back-to-back requests need at least one IDLE cycle.
REQ-018 Arithmetic SHALL be radix-2 iterative, one bit per cycle, with exactly WIDTH cycles in BUSY.
REQ-019 Latency: md_over SHALL be high exactly in the (WIDTH+1)th cycle after the accepting edge (cycle 33 for WIDTH=32), for one cycle.
REQ-020 md_hi and md_lo SHALL update only on the BUSY->DONE edge, then hold until the next completion, reset, or nothing else.
REQ-021 Sign handling for MULT and DIV:
- Operands are converted to magnitudes at accept.
- Signs are fixed up at BUSY->DONE.
- MULT result = two's-complement {hi,lo} of the 2*WIDTH-bit product.
- DIV quotient sign = sign1 XOR sign2; remainder sign = dividend sign (truncating division).
REQ-022 The most-negative operand SHALL be handled correctly: MULT 0x80000000*0x80000000 gives HI=0x40000000, LO=0.
REQ-023 Divide by zero SHALL keep the normal latency and produce:
- md_div_zero=1.
- LO = all ones.
- HI = md_src1 unmodified.
REQ-024 md_div_zero SHALL be cleared at every other completion.
REQ-025 md_cancel in BUSY or DONE SHALL force IDLE at the next edge.
REQ-026 A cancelled operation SHALL produce no md_over, and HI, LO and md_div_zero SHALL stay unchanged.
REQ-027 md_cancel and md_valid high together in IDLE: the cancel SHALL win and no request is accepted.
REQ-028 md_busy SHALL be a registered decode of the state, with no combinational path from any input.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE from any state, including mid-operation, with precedence over md_valid and md_cancel.
REQ-030 Reset values SHALL be: md_busy=0, md_over=0, md_hi=0, md_lo=0, md_div_zero=0, counter=0.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: the divider is compiled in and DIV/DIVU behave per REQ-021 and REQ-023.
REQ-032 Macro MULDIV_DIV_EN undefined: no divider datapath is compiled in.
- DIV/DIVU are still accepted and complete with the same WIDTH+1 latency.
- They return HI=LO=0 and md_div_zero=0.
- MULT/MULTU are unaffected.

Verification
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF, WIDTH=32 -> HI=0xFFFFFFFE, LO=0x00000001; md_over in cycle 33 only; md_busy high cycles 1-33.
REQ-034 MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-035 With MULDIV_DIV_EN: DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> md_div_zero=1, LO=0xFFFFFFFF, HI=100; a following DIVU 100/7 -> LO=14, HI=2, md_div_zero=0.
REQ-036 MULTU 6*7 accepted, md_cancel in cycle 10 -> no md_over, HI/LO keep their previous values; a new request two cycles later completes normally.
REQ-037 md_valid held high during BUSY with changing md_src1 -> the first result is unaffected and no second completion occurs until re-accepted from IDLE; rst asserted in cycle 5 -> all outputs 0 at the next edge.
REQ-038 WIDTH=8 build: MULT 0x80*0x7F -> HI=0xC0, LO=0x80, md_over in cycle 9; without MULDIV_DIV_EN, DIVU 9/3 -> HI=LO=0 in cycle 9.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative radix-2 multiply/divide unit for the EXE stage.
// Operations: MULT, MULTU, DIV, DIVU; one result bit per cycle, WIDTH+1 latency.
// Optional macro MULDIV_DIV_EN compiles in the restoring divider; without it
// DIV/DIVU are still accepted, keep the same latency, and return zero.
module exe_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_src1,
    input  logic [WIDTH-1:0] md_src2,
    input  logic             md_cancel,
    output logic             md_busy,
    output logic             md_over,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo,
    output logic             md_div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // control state
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             over_q;

    // captured operation and iteration registers
    logic             is_div_q;
    logic             neg_q;      // product / quotient must be negated at the end
    logic [WIDTH-1:0] opb_q;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_q;      // product upper half or partial remainder
    logic [WIDTH-1:0] sh_q;       // multiplier bits / dividend bits -> product lower half / quotient
`ifdef MULDIV_DIV_EN
    logic             rneg_q;     // remainder takes the dividend sign
    logic             div0_q;     // divisor was zero at accept
    logic [WIDTH-1:0] src1_q;     // raw dividend, returned as HI on divide by zero
`endif

    // architectural results
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dz_q;

    logic             accept;
    logic             finish;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   mul_sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
`endif
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sh_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dz;

    // cancel wins over a same-cycle request and over the final iteration
    assign accept = (state_q == S_IDLE) && md_valid && !md_cancel;
    assign finish = (state_q == S_BUSY) && (cnt_q == LAST) && !md_cancel;

    // Operand signs and magnitudes; unsigned ops (md_op[0]=1) never negate.
    always_comb begin
        s1   = !md_op[0] && md_src1[WIDTH-1];
        s2   = !md_op[0] && md_src2[WIDTH-1];
        mag1 = s1 ? -md_src1 : md_src1;
        mag2 = s2 ? -md_src2 : md_src2;
    end

    // One radix-2 step: shift-add multiply, or restoring divide when enabled.
    always_comb begin
        mul_sum = {1'b0, acc_q} + ({(WIDTH+1){sh_q[0]}} & {1'b0, opb_q});
        acc_d   = mul_sum[WIDTH:1];
        sh_d    = {mul_sum[0], sh_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_sh   = {acc_q, sh_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        if (is_div_q) begin
            // borrow out of the trial subtract means the divisor did not fit
            acc_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
`endif
    end

    // Sign fix-up of the final step's outcome, written on BUSY->DONE.
    always_comb begin
        prod = {acc_d, sh_d};
        if (neg_q) prod = -prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        res_dz = 1'b0;
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
            if (div0_q) begin
                res_hi = src1_q;
                res_lo = '1;
                res_dz = 1'b1;
            end else begin
                res_lo = neg_q  ? -sh_d  : sh_d;
                res_hi = rneg_q ? -acc_d : acc_d;
            end
`else
            res_hi = '0;
            res_lo = '0;
`endif
        end
    end

    // Control FSM; busy and over are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            over_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (md_valid && !md_cancel) begin
                        state_q <= S_BUSY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (md_cancel) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        over_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Capture operands at accept, then advance one step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            src1_q   <= '0;
`endif
        end else if (accept) begin
            is_div_q <= md_op[1];
            neg_q    <= s1 ^ s2;
            opb_q    <= mag2;
            acc_q    <= '0;
            sh_q     <= mag1;
`ifdef MULDIV_DIV_EN
            rneg_q   <= s1;
            div0_q   <= (md_src2 == '0);
            src1_q   <= md_src1;
`endif
        end else if (state_q == S_BUSY) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
        end
    end

    // HI/LO/div_zero change only on a non-cancelled completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else if (finish) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
            dz_q <= res_dz;
        end
    end

    assign md_busy     = busy_q;
    assign md_over     = over_q;
    assign md_hi       = hi_q;
    assign md_lo       = lo_q;
    assign md_div_zero = dz_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: scoreboard bench for exe_muldiv (WIDTH=32 and WIDTH=8 instances).
module tb_exe_muldiv;
    localparam int W  = 32;
    localparam int W8 = 8;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          md_valid = 1'b0;
    logic [1:0]    md_op = 2'b00;
    logic [W-1:0]  md_src1 = '0;
    logic [W-1:0]  md_src2 = '0;
    logic          md_cancel = 1'b0;
    logic          md_busy, md_over, md_div_zero;
    logic [W-1:0]  md_hi, md_lo;

    logic          v8 = 1'b0;
    logic [1:0]    op8 = 2'b00;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          c8 = 1'b0;
    logic          busy8, over8, dz8;
    logic [W8-1:0] hi8, lo8;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   win_lo = 1 << 30;
    int   win_hi = -1;
    bit   mon_en = 1'b0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    logic         last_dz = 1'b0;

    exe_muldiv #(.WIDTH(W), .CNT_W(6)) u32 (
        .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op),
        .md_src1(md_src1), .md_src2(md_src2), .md_cancel(md_cancel),
        .md_busy(md_busy), .md_over(md_over), .md_hi(md_hi), .md_lo(md_lo),
        .md_div_zero(md_div_zero)
    );

    exe_muldiv #(.WIDTH(W8), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .md_valid(v8), .md_op(op8),
        .md_src1(a8), .md_src2(b8), .md_cancel(c8),
        .md_busy(busy8), .md_over(over8), .md_hi(hi8), .md_lo(lo8),
        .md_div_zero(dz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=32 monitor: busy window every cycle, results on every md_over
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy32", 64'(md_busy), 64'((cyc >= win_lo) && (cyc <= win_hi)));
            if (md_over === 1'b1) begin
                if (q32.size() == 0) begin
                    chk("spurious_over32", 64'(md_over), 64'd0);
                end else begin
                    e32 = q32.pop_front();
                    chk("over_cycle32", 64'(cyc), 64'(e32.cyc));
                    chk("hi32", 64'(md_hi), e32.hi);
                    chk("lo32", 64'(md_lo), e32.lo);
                    chk("dz32", 64'(md_div_zero), 64'(e32.dz));
                end
            end
        end
    end

    // WIDTH=8 monitor
    always @(negedge clk) begin
        if (mon_en && over8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("spurious_over8", 64'(over8), 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("over_cycle8", 64'(cyc), 64'(e8.cyc));
                chk("hi8", 64'(hi8), e8.hi);
                chk("lo8", 64'(lo8), e8.lo);
                chk("dz8", 64'(dz8), 64'(e8.dz));
            end
        end
    end

    // accept edge is the next posedge (E); busy for cycles E..E+W, over at E+W
    task automatic issue32(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                           input bit keep);
        exp_t e;
        md_op = op; md_src1 = a; md_src2 = b; md_valid = 1'b1;
        win_lo = cyc + 1;
        win_hi = cyc + 1 + W;
        e.hi = 64'(eh); e.lo = 64'(el); e.dz = edz; e.cyc = cyc + 1 + W;
        q32.push_back(e);
        last_hi = eh; last_lo = el; last_dz = edz;
        tick();
        if (!keep) md_valid = 1'b0;
    endtask

    task automatic wait32();
        int n = 0;
        while (q32.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain32", 64'(q32.size()), 64'd0);
        q32.delete();
        tick();
    endtask

    task automatic issue8(input logic [1:0] op, input logic [W8-1:0] a, input logic [W8-1:0] b,
                          input logic [W8-1:0] eh, input logic [W8-1:0] el, input logic edz);
        exp_t e;
        op8 = op; a8 = a; b8 = b; v8 = 1'b1;
        e.hi = 64'(eh); e.lo = 64'(el); e.dz = edz; e.cyc = cyc + 1 + W8;
        q8.push_back(e);
        tick();
        v8 = 1'b0;
    endtask

    task automatic wait8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain8", 64'(q8.size()), 64'd0);
        q8.delete();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_over", 64'(md_over), 64'd0);
        chk("rst_hi",   64'(md_hi),   64'd0);
        chk("rst_lo",   64'(md_lo),   64'd0);
        chk("rst_dz",   64'(md_div_zero), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // multiply vectors
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0); wait32();
        issue32(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0); wait32();
        issue32(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0); wait32();
        issue32(2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 1'b0); wait32();

        // divide vectors
`ifdef MULDIV_DIV_EN
        issue32(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0); wait32();
        issue32(2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1'b0); wait32();
        issue32(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0); wait32();
        issue32(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0); wait32();
`else
        issue32(2'b10, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        1'b0, 1'b0); wait32();
        issue32(2'b11, 32'd100,      32'd0,        32'd0,        32'd0,        1'b0, 1'b0); wait32();
        issue32(2'b11, 32'd100,      32'd7,        32'd0,        32'd0,        1'b0, 1'b0); wait32();
`endif

        // cancel in cycle 10: no completion, results untouched
        md_op = 2'b01; md_src1 = 32'd6; md_src2 = 32'd7; md_valid = 1'b1;
        win_lo = cyc + 1;
        win_hi = cyc + 1 + W;
        tick();
        md_valid = 1'b0;
        repeat (9) tick();
        md_cancel = 1'b1;
        win_hi = cyc;
        tick();
        md_cancel = 1'b0;
        chk("cancel_hi", 64'(md_hi), 64'(last_hi));
        chk("cancel_lo", 64'(md_lo), 64'(last_lo));
        chk("cancel_dz", 64'(md_div_zero), 64'(last_dz));
        tick();
        issue32(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0); wait32();

        // md_valid held with changing operands during BUSY
        issue32(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            md_src1 = 32'(i * 13 + 1);
            md_src2 = 32'(i * 7 + 2);
            md_op   = 2'(i);
            tick();
        end
        md_valid = 1'b0;
        wait32();

        // reset in cycle 5 of an operation
        md_op = 2'b01; md_src1 = 32'd2; md_src2 = 32'd3; md_valid = 1'b1;
        win_lo = cyc + 1;
        win_hi = cyc + 1 + W;
        tick();
        md_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        win_hi = cyc;
        tick();
        chk("midrst_busy", 64'(md_busy), 64'd0);
        chk("midrst_over", 64'(md_over), 64'd0);
        chk("midrst_hi",   64'(md_hi),   64'd0);
        chk("midrst_lo",   64'(md_lo),   64'd0);
        chk("midrst_dz",   64'(md_div_zero), 64'd0);
        rst = 1'b0;
        tick();

        // cancel and valid together in IDLE: nothing accepted
        md_op = 2'b01; md_src1 = 32'd9; md_src2 = 32'd9;
        md_valid = 1'b1; md_cancel = 1'b1;
        tick();
        md_valid = 1'b0; md_cancel = 1'b0;
        repeat (W + 4) tick();
        chk("idlecancel_hi", 64'(md_hi), 64'd0);
        chk("idlecancel_lo", 64'(md_lo), 64'd0);

        // WIDTH=8 instance
        issue8(2'b00, 8'h80, 8'h7F, 8'hC0, 8'h80, 1'b0); wait8();
        issue8(2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0); wait8();
`ifdef MULDIV_DIV_EN
        issue8(2'b11, 8'd9, 8'd3, 8'd0, 8'd3, 1'b0); wait8();
`else
        issue8(2'b11, 8'd9, 8'd3, 8'd0, 8'd0, 1'b0); wait8();
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
